// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage data-memory sequencer. A load/store in EX/MEM becomes one
// req/ack transaction on the data-memory port. Upstream pipeline registers
// are frozen while it is outstanding, and a transaction that never completes
// is aborted after TIMEOUT cycles.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   memread, memwrite    EX/MEM controls (never both 1)
//   addr, write_data     EX/MEM byte address and store data
//   dmem_ack, dmem_rdata memory completion and read data (ACCESS only)
//   dmem_req/we/addr/wdata  registered memory request port
//   stall                freeze PC, IF/ID, ID/EX, EX/MEM; hold MEM/WB
//   read_data            registered load data to MEM/WB
//   wb_kill              squash regwrite of the instruction entering MEM/WB
//   bus_error            one-cycle pulse in DONE after a timeout
//   misaligned           memory op with addr[1:0] != 0 seen in IDLE
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        wb_kill,
    output logic        bus_error,
    output logic        misaligned
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          err_flag;

    logic memop, unaligned, start, timeout;

    assign memop     = memread | memwrite;
    assign unaligned = addr[1:0] != 2'b00;
    assign start     = (state == IDLE) && memop && !unaligned;
    // An ack on the last allowed cycle still counts as success.
    assign timeout   = (state == ACCESS) && !dmem_ack && (cnt == CNT_LAST);

    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        wb_kill    = 1'b0;
        case (state)
            IDLE: begin
                if (memop && unaligned) begin
                    misaligned = 1'b1;
                    wb_kill    = 1'b1;
                end else if (memop) begin
                    stall     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (dmem_ack || timeout)
                    state_nxt = DONE;
            end
            DONE: begin
                // Any memop still visible here is the instruction just serviced.
                wb_kill   = err_flag;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Combinational outputs read as 0 while reset is held.
        if (reset) begin
            stall      = 1'b0;
            misaligned = 1'b0;
            wb_kill    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            err_flag   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            read_data  <= '0;
            bus_error  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= memwrite;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_wdata <= write_data;
                        cnt        <= '0;
                    end else if (memop) begin
                        // Misaligned op passes through with zeroed load data.
                        read_data <= '0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        read_data <= dmem_we ? 32'h0 : dmem_rdata;
                    end else if (timeout) begin
                        dmem_req  <= 1'b0;
                        read_data <= '0;
                        bus_error <= 1'b1;
                        err_flag  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    err_flag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        memread, memwrite;
    logic [31:0] addr, write_data;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        stall;
    logic [31:0] read_data;
    logic        wb_kill, bus_error, misaligned;

    int checks   = 0;
    int failures = 0;
    int stall_cycles;

    always #5 clock = ~clock;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .memread(memread), .memwrite(memwrite),
        .addr(addr), .write_data(write_data),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .stall(stall), .read_data(read_data),
        .wb_kill(wb_kill), .bus_error(bus_error),
        .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  {31'b0, dmem_req},   32'h0);
        chk({tag, "_we"},   {31'b0, dmem_we},    32'h0);
        chk({tag, "_addr"}, dmem_addr,           32'h0);
        chk({tag, "_wd"},   dmem_wdata,          32'h0);
        chk({tag, "_rd"},   read_data,           32'h0);
        chk({tag, "_be"},   {31'b0, bus_error},  32'h0);
        chk({tag, "_st"},   {31'b0, stall},      32'h0);
        chk({tag, "_mis"},  {31'b0, misaligned}, 32'h0);
        chk({tag, "_wk"},   {31'b0, wb_kill},    32'h0);
    endtask

    initial begin
        reset = 1'b1; memread = 1'b1; memwrite = 1'b0;
        addr = 32'h0000_0100; write_data = 32'h0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;

        // Reset held 2 cycles with memread asserted.
        cyc(); chk_all_zero("rst1");
        cyc(); chk_all_zero("rst2");

        // Zero-wait load, cycle 0 (IDLE).
        reset = 1'b0; #1;
        chk("ld_c0_stall", {31'b0, stall}, 32'h1);
        chk("ld_c0_req",   {31'b0, dmem_req}, 32'h0);
        cyc();  // cycle 1: ACCESS
        chk("ld_c1_req",   {31'b0, dmem_req}, 32'h1);
        chk("ld_c1_stall", {31'b0, stall}, 32'h1);
        chk("ld_c1_addr",  dmem_addr, 32'h0000_0100);
        chk("ld_c1_we",    {31'b0, dmem_we}, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        cyc();  // cycle 2: DONE
        dmem_ack = 1'b0; #1;
        chk("ld_c2_stall", {31'b0, stall}, 32'h0);
        chk("ld_c2_rd",    read_data, 32'hDEAD_BEEF);
        chk("ld_c2_wk",    {31'b0, wb_kill}, 32'h0);
        chk("ld_c2_req",   {31'b0, dmem_req}, 32'h0);

        // Wait-state store, back-to-back: ack in the 3rd ACCESS cycle.
        memread = 1'b0; memwrite = 1'b1; addr = 32'h0000_0040; write_data = 32'h1234_5678;
        #1;
        chk("st_done_stall", {31'b0, stall}, 32'h0);
        stall_cycles = 0;
        cyc();  // IDLE
        chk("st_idle_stall", {31'b0, stall}, 32'h1);
        if (stall) stall_cycles++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) begin dmem_ack = 1'b1; #1; end
            chk("st_acc_req",   {31'b0, dmem_req}, 32'h1);
            chk("st_acc_we",    {31'b0, dmem_we},  32'h1);
            chk("st_acc_wd",    dmem_wdata, 32'h1234_5678);
            chk("st_acc_addr",  dmem_addr,  32'h0000_0040);
            if (stall) stall_cycles++;
        end
        cyc();  // DONE
        dmem_ack = 1'b0;
        memwrite = 1'b0; memread = 1'b1; addr = 32'h0000_0200;
        #1;
        chk("st_stall_total", stall_cycles, 32'd4);
        chk("st_done_stall",  {31'b0, stall}, 32'h0);
        chk("st_done_rd",     read_data, 32'h0);
        chk("st_done_req",    {31'b0, dmem_req}, 32'h0);

        // Timeout with TIMEOUT = 4, never acked.
        cyc();  // IDLE
        chk("to_idle_stall", {31'b0, stall}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("to_acc_req", {31'b0, dmem_req}, 32'h1);
            chk("to_acc_be",  {31'b0, bus_error}, 32'h0);
        end
        addr = 32'h0000_0300;
        cyc();  // DONE
        chk("to_done_req", {31'b0, dmem_req}, 32'h0);
        chk("to_done_be",  {31'b0, bus_error}, 32'h1);
        chk("to_done_wk",  {31'b0, wb_kill}, 32'h1);
        chk("to_done_rd",  read_data, 32'h0);
        chk("to_done_st",  {31'b0, stall}, 32'h0);

        // Ack on the timeout cycle.
        cyc();  // IDLE
        chk("ta_idle_be", {31'b0, bus_error}, 32'h0);
        chk("ta_idle_wk", {31'b0, wb_kill}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ta_acc_req", {31'b0, dmem_req}, 32'h1);
            if (i == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_A5A5; end
        end
        cyc();  // DONE
        dmem_ack = 1'b0;
        memread = 1'b1; addr = 32'h0000_0102;
        #1;
        chk("ta_done_be",  {31'b0, bus_error}, 32'h0);
        chk("ta_done_wk",  {31'b0, wb_kill}, 32'h0);
        chk("ta_done_rd",  read_data, 32'hA5A5_A5A5);
        chk("ta_done_req", {31'b0, dmem_req}, 32'h0);

        // Misaligned load passes through without a request.
        cyc();  // IDLE
        chk("mis_flag",  {31'b0, misaligned}, 32'h1);
        chk("mis_wk",    {31'b0, wb_kill}, 32'h1);
        chk("mis_stall", {31'b0, stall}, 32'h0);
        cyc();
        chk("mis_req",   {31'b0, dmem_req}, 32'h0);
        chk("mis_rd",    read_data, 32'h0);
        memread = 1'b0; #1;
        chk("mis_clr",   {31'b0, misaligned}, 32'h0);
        chk("mis_wkclr", {31'b0, wb_kill}, 32'h0);

        // Reset in the 2nd ACCESS cycle, late ack ignored.
        memread = 1'b1; addr = 32'h0000_0400;
        cyc();  // ACCESS 1
        chk("rm_acc1_req", {31'b0, dmem_req}, 32'h1);
        cyc();  // ACCESS 2
        reset = 1'b1;
        cyc();
        chk("rm_req",   {31'b0, dmem_req}, 32'h0);
        chk("rm_stall", {31'b0, stall}, 32'h0);
        reset = 1'b0; memread = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        cyc();
        dmem_ack = 1'b0; #1;
        chk("rm_late_req", {31'b0, dmem_req}, 32'h0);
        chk("rm_late_rd",  read_data, 32'h0);
        chk("rm_late_be",  {31'b0, bus_error}, 32'h0);
        chk("rm_late_st",  {31'b0, stall}, 32'h0);

        // Controller recovers and issues a fresh request.
        memread = 1'b1; addr = 32'h0000_0500;
        cyc();
        chk("rm_new_req",  {31'b0, dmem_req}, 32'h1);
        chk("rm_new_addr", dmem_addr, 32'h0000_0500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the run in case the sequence stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage data-memory access in the 5-stage RISC-V pipeline.
- Turns the EX/MEM memread/memwrite controls into a req/ack transaction on the data-memory port, with a timeout.
- Freezes the upstream pipeline registers while a transaction is outstanding.
- Presents the captured load data and a writeback-kill flag to the MEM/WB register on the single cycle the pipeline advances.

## Interface
Parameters:
- TIMEOUT, 16: maximum ACCESS-state cycles without dmem_ack before aborting; legal range 2..255.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- memread  in  1  EX/MEM control, load in MEM stage.
- memwrite  in  1  EX/MEM control, store in MEM stage; memread and memwrite are never both 1.
- addr  in  32  EX/MEM ALU result, byte address.
- write_data  in  32  EX/MEM store data.
- dmem_ack  in  1  memory completion, sampled only in ACCESS.
- dmem_rdata  in  32  memory read data, valid with dmem_ack.
- dmem_req  out  1  registered request, held high for the whole ACCESS state.
- dmem_we  out  1  registered, 1 = store.
- dmem_addr  out  32  registered, word-aligned address.
- dmem_wdata  out  32  registered store data.
- stall  out  1  combinational, freezes PC, IF/ID, ID/EX and EX/MEM and holds MEM/WB load off.
- read_data  out  32  registered load data fed to MEM/WB read_data_in.
- wb_kill  out  1  squashes regwrite of the instruction entering MEM/WB.
- bus_error  out  1  one-cycle pulse on timeout.
- misaligned  out  1  combinational, memory op with addr[1:0] != 0 in IDLE.

## Operation
- States: IDLE, ACCESS, DONE; 2-bit encoding.
- IDLE, no memory op:
  - stall = 0.
  - Next state is IDLE.
- IDLE, memory op with addr[1:0] != 0:
  - misaligned = 1, wb_kill = 1, stall = 0.
  - No request is issued and the instruction passes through.
  - read_data is forced to 0.
- IDLE, aligned memory op:
  - stall = 1.
  - On the edge, load dmem_addr = addr, dmem_wdata = write_data, dmem_we = memwrite, dmem_req = 1.
  - Clear the timeout counter and go to ACCESS.
- ACCESS:
  - stall = 1.
  - dmem_addr, dmem_wdata and dmem_we are held constant.
  - dmem_ack = 1: capture read_data = dmem_rdata for loads (0 for stores), drop dmem_req, go to DONE.
  - No ack and counter == TIMEOUT-1: drop dmem_req, set read_data = 0, pulse bus_error and latch the error flag, go to DONE.
  - Otherwise increment the counter.
  - dmem_ack on the timeout cycle: the ack wins and no error is raised.
- DONE:
  - stall = 0, so the pipeline advances on this edge.
  - wb_kill = latched error flag.
  - Go to IDLE unconditionally and clear the error flag.
  - A memory op visible in DONE is the already-serviced instruction and is ignored.
- dmem_ack outside ACCESS is ignored.
- The counter is $clog2(TIMEOUT)+1 bits and saturates in no other state.

## Timing
- Reset value of every output: 0. State = IDLE, counter = 0, error flag = 0.
- Zero-wait memory (ack in the first ACCESS cycle):
  - Cycle 0: IDLE, stall = 1.
  - Cycle 1: ACCESS, req = 1, ack = 1.
  - Cycle 2: DONE, read_data valid, stall = 0.
  - Each memory op therefore costs 3 cycles, i.e. 2 stall cycles.
- Each extra wait cycle before ack adds exactly 1 stall cycle.
- Timeout path:
  - dmem_req is high for exactly TIMEOUT cycles.
  - bus_error is high in the DONE cycle only.
- Back-to-back memory ops: the next op's IDLE cycle directly follows DONE, with no extra gap.
- Reset asserted in any state takes effect on the next edge:
  - dmem_req falls and state goes to IDLE.
  - An in-flight transaction is abandoned; a late ack is ignored.
- stall, misaligned and wb_kill are combinational from state and inputs. All other outputs are registered.

## Test plan
- Reset:
  - Stimulus: hold reset for 2 cycles with memread = 1.
  - Required: all outputs 0 and state IDLE. After release, dmem_req rises one cycle later.
- Zero-wait load:
  - Stimulus: memread = 1, addr = 0x0000_0100; ack in the first ACCESS cycle with dmem_rdata = 0xDEAD_BEEF.
  - Required: stall high for cycles 0-1 and low in cycle 2; read_data = 0xDEAD_BEEF in cycle 2; wb_kill = 0.
- Wait-state store:
  - Stimulus: memwrite = 1, addr = 0x0000_0040, write_data = 0x1234_5678; ack after 3 ACCESS cycles.
  - Required: dmem_we = 1 and dmem_wdata = 0x1234_5678 held for all 3 cycles; 4 stall cycles total; read_data = 0.
- Timeout, TIMEOUT = 4:
  - Stimulus: memread = 1, never ack.
  - Required: dmem_req high exactly 4 cycles; bus_error and wb_kill both high in the DONE cycle; read_data = 0.
- Ack on the timeout cycle:
  - Stimulus: ack arrives in the TIMEOUT-th ACCESS cycle with dmem_rdata = 0xA5A5_A5A5.
  - Required: bus_error = 0; read_data = 0xA5A5_A5A5.
- Misaligned access and reset mid-access:
  - Misaligned stimulus: memread = 1, addr = 0x0000_0102.
  - Misaligned required: misaligned = 1, wb_kill = 1, stall = 0, dmem_req never rises.
  - Reset stimulus: assert reset in the 2nd ACCESS cycle, then ack one cycle later.
  - Reset required: dmem_req low after that edge and the late ack is ignored.
